// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: byte-wide instruction memory port, decoder valid/ready handshake and jump redirect.
// master = fetch unit, slave = memory/controller side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 13
);
    logic [7:0]        command;
    logic [ADDR_W-1:0] address;
    logic              mem_read;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        opcode_byte;
    logic [ADDR_W-1:0] operand_addr;
    logic              instr_len;
    logic [ADDR_W-1:0] instr_pc;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_target;

    modport master (
        input  command, instr_ready, jmp_valid, jmp_target,
        output address, mem_read, instr_valid, opcode_byte, operand_addr, instr_len, instr_pc
    );

    modport slave (
        output command, instr_ready, jmp_valid, jmp_target,
        input  address, mem_read, instr_valid, opcode_byte, operand_addr, instr_len, instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 1- or 2-byte instructions from byte-wide memory and
// presents them to the controller with valid/ready; jump redirects flush the current instruction.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 13,
    parameter logic [12:0] RESET_PC = 13'd0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_FETCH_HI = 2'd1,
        ST_FETCH_LO = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_opcode_byte;
    logic [ADDR_W-1:0] r_operand_addr;
    logic              r_instr_len;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_mem_read;

    logic w_ld_opcode;
    logic w_ld_operand;
    logic w_clr_operand;
    logic w_pc_inc;
    logic w_valid_nxt;
    logic w_mem_read_nxt;

    // LDA (000), STA (001) and JMP (110) carry a second address byte
    function automatic logic is_two_byte(input logic [7:0] op);
        case (op[7:5])
            3'b000, 3'b001, 3'b110: is_two_byte = 1'b1;
            default:                is_two_byte = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_START;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_START:    w_next_state = ST_FETCH_HI;
            ST_FETCH_HI: w_next_state = is_two_byte(bus.command) ? ST_FETCH_LO : ST_HOLD;
            ST_FETCH_LO: w_next_state = ST_HOLD;
            ST_HOLD:     if (bus.instr_ready) w_next_state = ST_FETCH_HI;
            default:     w_next_state = ST_START;
        endcase
        // a redirect overrides every state and drops any partial or held instruction
        if (bus.jmp_valid) w_next_state = ST_FETCH_HI;
    end

    always_comb begin
        w_ld_opcode   = 1'b0;
        w_ld_operand  = 1'b0;
        w_clr_operand = 1'b0;
        w_pc_inc      = 1'b0;
        if (!bus.jmp_valid) begin
            case (r_state)
                ST_FETCH_HI: begin
                    w_ld_opcode   = 1'b1;
                    w_pc_inc      = 1'b1;
                    w_clr_operand = !is_two_byte(bus.command);
                end
                ST_FETCH_LO: begin
                    w_ld_operand = 1'b1;
                    w_pc_inc     = 1'b1;
                end
                default: ;
            endcase
        end
        w_valid_nxt    = (w_next_state == ST_HOLD);
        w_mem_read_nxt = (w_next_state == ST_FETCH_HI) || (w_next_state == ST_FETCH_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc           <= ADDR_W'(RESET_PC);
            r_opcode_byte  <= 8'd0;
            r_operand_addr <= '0;
            r_instr_len    <= 1'b0;
            r_instr_pc     <= '0;
            r_instr_valid  <= 1'b0;
            r_mem_read     <= 1'b0;
        end else begin
            r_instr_valid <= w_valid_nxt;
            r_mem_read    <= w_mem_read_nxt;
            if (bus.jmp_valid)  r_pc <= bus.jmp_target;
            else if (w_pc_inc)  r_pc <= r_pc + ADDR_W'(1);
            if (w_ld_opcode) begin
                r_opcode_byte <= bus.command;
                r_instr_pc    <= r_pc;
            end
            if (w_clr_operand) begin
                r_operand_addr <= '0;
                r_instr_len    <= 1'b0;
            end else if (w_ld_operand) begin
                r_operand_addr <= ADDR_W'({r_opcode_byte[4:0], bus.command});
                r_instr_len    <= 1'b1;
            end
        end
    end

    assign bus.address      = r_pc;
    assign bus.mem_read     = r_mem_read;
    assign bus.instr_valid  = r_instr_valid;
    assign bus.opcode_byte  = r_opcode_byte;
    assign bus.operand_addr = r_operand_addr;
    assign bus.instr_len    = r_instr_len;
    assign bus.instr_pc     = r_instr_pc;
endmodule
